// File: rtl/replay_ack_gen_pkg.sv
// Shared types for the receive-side replay ack generator (replay_ack_gen).
// AckGenOut mirrors the ack/ack_count/nack fields of the transmit ReplayBufferIn.
package replay_ack_gen_pkg;

  localparam int ack_count_width = 4;

  typedef enum logic [1:0] {
    RUN,
    NACK_SEND,
    RECOVER
  } AckGenState;

  typedef struct packed {
    logic                       ack;
    logic [ack_count_width-1:0] ack_count;
    logic                       nack;
  } AckGenOut;

  // Bits needed to hold values 0..max_value, never less than one.
  function automatic int counter_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/replay_ack_gen_ack_coalescer.sv
// Pending-ack counter and idle timer: emits a registered ack with its count on the
// coalescing threshold, on an idle timeout, or when the top asks for a flush.
module replay_ack_gen_ack_coalescer
  import replay_ack_gen_pkg::*;
#(
  parameter int seq_width    = 4,
  parameter int ack_coalesce = 4,
  parameter int ack_timeout  = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 accept,
  input  logic                 flush,
  output logic                 ack,
  output logic [seq_width-1:0] ack_count
);

  localparam int idle_width = counter_width(ack_timeout);
  localparam logic [idle_width-1:0] idle_last = idle_width'(ack_timeout - 1);
  localparam logic [seq_width-1:0] coalesce_level = seq_width'(ack_coalesce);

  logic [seq_width-1:0]  pending;
  logic [seq_width-1:0]  pending_sum;
  logic [idle_width-1:0] idle_cnt;
  logic                  fire;

  assign pending_sum = pending + seq_width'(accept);

  // A timeout or flush with nothing outstanding must stay silent.
  assign fire = (accept && (pending_sum == coalesce_level)) ||
                ((pending != '0) && (flush || (idle_cnt == idle_last)));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending   <= '0;
      idle_cnt  <= '0;
      ack       <= 1'b0;
      ack_count <= '0;
    end else begin
      ack       <= fire;
      ack_count <= fire ? pending_sum : '0;
      if (fire) begin
        pending  <= '0;
        idle_cnt <= '0;
      end else if (accept) begin
        pending  <= pending_sum;
        idle_cnt <= '0;
      end else if (idle_cnt != idle_last) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/replay_ack_gen.sv
// Receive-side link stage: sequence check, drop-until-replay recovery, ack/nack return.
// Optional build macro ACK_GEN_PARITY_EN: in_packet MSB is even parity over the rest.
module replay_ack_gen
  import replay_ack_gen_pkg::*;
#(
  parameter int packet_width = 64,
  parameter int seq_width    = 4,
  parameter int ack_coalesce = 4,
  parameter int ack_timeout  = 32,
  parameter int nack_timeout = 64
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    in_valid,
  input  logic [packet_width-1:0] in_packet,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [packet_width-1:0] out_packet,
  input  logic                    out_ready,
  output logic                    ack,
  output logic [seq_width-1:0]    ack_count,
  output logic                    nack
);

  localparam int rec_width = counter_width(nack_timeout);
  localparam logic [rec_width-1:0] rec_last = rec_width'(nack_timeout - 1);

  AckGenState           state;
  AckGenState           state_next;
  logic [seq_width-1:0] expected_seq;
  logic [rec_width-1:0] rec_cnt;
  logic                 nack_q;
  logic                 xfer;
  logic                 parity_ok;
  logic                 pkt_good;
  logic                 accept;
  logic                 flush;
  logic                 coal_ack;
  logic [seq_width-1:0] coal_count;
  AckGenOut             link_out;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

`ifdef ACK_GEN_PARITY_EN
  assign parity_ok = ~^in_packet;
`else
  assign parity_ok = 1'b1;
`endif

  assign pkt_good = (in_packet[seq_width-1:0] == expected_seq) && parity_ok;
  // Packets arriving while the nack is being issued are dropped even if in order.
  assign accept   = xfer && pkt_good && (state != NACK_SEND);
  assign flush    = xfer && !pkt_good && (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      RUN:       if (flush) state_next = NACK_SEND;
      NACK_SEND: state_next = RECOVER;
      RECOVER: begin
        if (accept)                  state_next = RUN;
        else if (rec_cnt == rec_last) state_next = NACK_SEND;
      end
      default:   state_next = RUN;
    endcase
  end

  // rec_cnt starts at zero in NACK_SEND so successive nacks are nack_timeout apart.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= RUN;
      rec_cnt <= '0;
      nack_q  <= 1'b0;
    end else begin
      state  <= state_next;
      nack_q <= (state == NACK_SEND);
      if (state_next == RECOVER) rec_cnt <= rec_cnt + 1'b1;
      else                       rec_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      expected_seq <= '0;
      out_valid    <= 1'b0;
      out_packet   <= '0;
    end else begin
      if (accept) begin
        expected_seq <= expected_seq + 1'b1;
        out_valid    <= 1'b1;
        out_packet   <= in_packet;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  replay_ack_gen_ack_coalescer #(
    .seq_width   (seq_width),
    .ack_coalesce(ack_coalesce),
    .ack_timeout (ack_timeout)
  ) u_coalescer (
    .clk      (clk),
    .nreset   (nreset),
    .accept   (accept),
    .flush    (flush),
    .ack      (coal_ack),
    .ack_count(coal_count)
  );

  assign link_out.ack       = coal_ack;
  assign link_out.ack_count = ack_count_width'(coal_count);
  assign link_out.nack      = nack_q;

  assign ack       = link_out.ack;
  assign ack_count = seq_width'(link_out.ack_count);
  assign nack      = link_out.nack;

endmodule

// File: tb/tb_replay_ack_gen.sv
// Self-checking bench for replay_ack_gen: vector table, directed corner sequences and
// randomized traffic against a reference model. Honours ACK_GEN_PARITY_EN when defined.
module tb_replay_ack_gen;

  localparam int coalesce_n   = 4;
  localparam int ack_idle_n   = 32;
  localparam int nack_every_n = 64;

  logic        clk;
  logic        nreset;
  logic        in_valid;
  logic [63:0] in_packet;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_packet;
  logic        out_ready;
  logic        ack;
  logic [3:0]  ack_count;
  logic        nack;

  int compared;
  int mismatched;

  replay_ack_gen dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_packet (in_packet),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_packet(out_packet),
    .out_ready (out_ready),
    .ack       (ack),
    .ack_count (ack_count),
    .nack      (nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = in sequence, 1 = nack owed, 2 = waiting for replay.
  int          m_exp;
  int          m_pending;
  int          m_idle;
  int          m_wait;
  int          m_mode;
  logic        m_ov;
  logic [63:0] m_op;
  logic        e_ack;
  int          e_count;
  logic        e_nack;

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] seq;
    logic       rdy;
    logic       e_ov;
    logic [3:0] e_seq;
    logic       e_ack;
    logic [3:0] e_cnt;
    logic       e_nack;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] make_pkt(input logic [3:0] seq, input logic flip);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[3:0] = seq;
`ifdef ACK_GEN_PARITY_EN
    p[63] = (^p[62:0]) ^ flip;
`else
    p[63] = p[63] ^ flip;
`endif
    return p;
  endfunction

  function automatic bit parity_good(input logic [63:0] p);
    bit ok;
    ok = 1'b1;
`ifdef ACK_GEN_PARITY_EN
    ok = ((^p) == 1'b0);
`endif
    return ok;
  endfunction

  task automatic modelReset();
    m_exp = 0; m_pending = 0; m_idle = 0; m_wait = 0; m_mode = 0;
    m_ov = 1'b0; m_op = '0;
  endtask

  task automatic modelStep(input logic v, input logic [63:0] p, input logic rdy);
    bit xfer, good, take, timeout;
    int old_mode, age;
    old_mode = m_mode;
    xfer = v && (!m_ov || rdy);
    good = (int'(p[3:0]) == m_exp) && parity_good(p);
    take = xfer && good && (old_mode != 1);
    e_ack = 1'b0; e_count = 0; e_nack = 1'b0;
    age = m_idle + 1;
    timeout = (m_pending > 0) && (age >= ack_idle_n);
    if (take) begin
      m_pending++;
      m_exp = (m_exp + 1) % 16;
    end
    if (old_mode == 0 && xfer && !good) begin
      if (m_pending > 0) begin e_ack = 1'b1; e_count = m_pending; end
      m_pending = 0; m_idle = 0; m_mode = 1;
    end else if (m_pending == coalesce_n || timeout) begin
      e_ack = 1'b1; e_count = m_pending; m_pending = 0; m_idle = 0;
    end else begin
      m_idle = take ? 0 : age;
    end
    if (old_mode == 1) begin
      e_nack = 1'b1; m_mode = 2; m_wait = 0;
    end else if (old_mode == 2) begin
      if (take) m_mode = 0;
      else begin
        m_wait++;
        if (m_wait == nack_every_n - 1) m_mode = 1;
      end
    end
    if (take) begin m_ov = 1'b1; m_op = p; end
    else if (rdy) m_ov = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] p, input logic rdy);
    in_valid = v; in_packet = p; out_ready = rdy;
    @(posedge clk);
    modelStep(v, p, rdy);
    #1;
    checkOutput("model in_ready", 64'(in_ready), 64'(!m_ov || rdy));
    checkOutput("model out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) checkOutput("model out_packet", out_packet, m_op);
    checkOutput("model ack", 64'(ack), 64'(e_ack));
    checkOutput("model ack_count", 64'(ack_count), 64'(e_count));
    checkOutput("model nack", 64'(nack), 64'(e_nack));
  endtask

  task automatic doReset();
    in_valid = 1'b0; out_ready = 1'b1;
    nreset = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_packet", out_packet, 64'd0);
    checkOutput("reset ack", 64'(ack), 64'd0);
    checkOutput("reset ack_count", 64'(ack_count), 64'd0);
    checkOutput("reset nack", 64'(nack), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    modelReset();
  endtask

  task automatic addVec(input logic rst, input logic v, input logic [3:0] seq, input logic rdy,
                        input logic e_ov, input logic [3:0] e_seq, input logic e_ack_v,
                        input logic [3:0] e_cnt, input logic e_nack_v);
    vec_t t;
    t.rst = rst; t.v = v; t.seq = seq; t.rdy = rdy; t.e_ov = e_ov; t.e_seq = e_seq;
    t.e_ack = e_ack_v; t.e_cnt = e_cnt; t.e_nack = e_nack_v;
    vecs.push_back(t);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] pkt;
    logic        v, rdy, flip;
    logic [3:0]  s;
    int          phase;

    compared = 0; mismatched = 0;
    in_valid = 1'b0; in_packet = '0; out_ready = 1'b1; nreset = 1'b1;
    modelReset();
    #2;

    // In-order burst with ack every fourth packet.
    for (int i = 0; i < 8; i++)
      addVec(i == 0, 1'b1, 4'(i), 1'b1, 1'b1, 4'(i), (i % 4) == 3, ((i % 4) == 3) ? 4'd4 : 4'd0, 1'b0);
    addVec(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    // Gap: flush ack, nack, silent drops, then replayed packet resumes.
    addVec(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    addVec(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
    addVec(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0);
    addVec(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    addVec(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    addVec(1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    addVec(1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].v, make_pkt(vecs[i].seq, 1'b0), vecs[i].rdy);
      checkOutput("vec out_valid", 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) checkOutput("vec out_seq", 64'(out_packet[3:0]), 64'(vecs[i].e_seq));
      checkOutput("vec ack", 64'(ack), 64'(vecs[i].e_ack));
      checkOutput("vec ack_count", 64'(ack_count), 64'(vecs[i].e_cnt));
      checkOutput("vec nack", 64'(nack), 64'(vecs[i].e_nack));
    end

    // Two packets then silence: timeout ack 32 cycles after the last accept.
    doReset();
    applyStimulus(1'b1, make_pkt(4'd0, 1'b0), 1'b1);
    applyStimulus(1'b1, make_pkt(4'd1, 1'b0), 1'b1);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("idle ack", 64'(ack), 64'(k == 32));
      checkOutput("idle ack_count", 64'(ack_count), (k == 32) ? 64'd2 : 64'd0);
      checkOutput("idle nack", 64'(nack), 64'd0);
    end

    // Gap with no replay: nack repeats every 64 cycles.
    doReset();
    applyStimulus(1'b1, make_pkt(4'd0, 1'b0), 1'b1);
    applyStimulus(1'b1, make_pkt(4'd2, 1'b0), 1'b1);
    checkOutput("gap ack_count", 64'(ack_count), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("gap first nack", 64'(nack), 64'd1);
    for (int n = 1; n <= 130; n++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("recover nack", 64'(nack), 64'(n == 64 || n == 128));
      checkOutput("recover ack", 64'(ack), 64'd0);
    end

    // Sequence wrap 15 -> 0.
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, make_pkt(4'(i % 16), 1'b0), 1'b1);
      checkOutput("wrap out_valid", 64'(out_valid), 64'd1);
      checkOutput("wrap out_seq", 64'(out_packet[3:0]), 64'(i % 16));
      checkOutput("wrap ack", 64'(ack), 64'((i % 4) == 3));
    end

`ifdef ACK_GEN_PARITY_EN
    doReset();
    applyStimulus(1'b1, make_pkt(4'd0, 1'b0), 1'b1);
    applyStimulus(1'b1, make_pkt(4'd1, 1'b0), 1'b1);
    applyStimulus(1'b1, make_pkt(4'd2, 1'b1), 1'b1);
    checkOutput("parity ack_count", 64'(ack_count), 64'd2);
    checkOutput("parity dropped", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("parity nack", 64'(nack), 64'd1);
    applyStimulus(1'b1, make_pkt(4'd2, 1'b0), 1'b1);
    checkOutput("parity replay accepted", 64'(out_valid), 64'd1);
`endif

    // Consumer stall holds the output, then reset lands mid-stream.
    doReset();
    held = make_pkt(4'd0, 1'b0);
    applyStimulus(1'b1, held, 1'b1);
    pkt = make_pkt(4'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, pkt, 1'b0);
      checkOutput("stall in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall out_packet", out_packet, held);
    end
    applyStimulus(1'b1, pkt, 1'b1);
    checkOutput("stall release", out_packet, pkt);
    doReset();

    // Randomized traffic in phases: dense, sparse, heavy backpressure, silent.
    phase = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c % 250 == 0) phase = $urandom_range(0, 3);
      case (phase)
        1:       v = ($urandom_range(0, 15) == 0);
        3:       v = 1'b0;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      rdy = (phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
      s = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(m_exp);
`ifdef ACK_GEN_PARITY_EN
      flip = ($urandom_range(0, 19) == 0);
`else
      flip = 1'b0;
`endif
      applyStimulus(v, make_pkt(s, flip), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
